// File: rtl/instr_encode_loader.sv
// Encodes decoded operation descriptors into RV32I words and streams them into IMEM.
// Optional build macro HALT_APPEND_EN appends a JAL x0,0 self-loop word after the session.
module instr_encode_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic              err_illegal
);

    typedef enum logic [1:0] {StIdle, StLoad, StDone, StHalt} state_e;

    localparam logic [ADDR_W-1:0] MaxAddr  = '1;
    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       HaltWord = 32'h0000_006F;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                pend_q, pend_d;
    logic                term_q, term_d;
    logic                full_q, full_d;
    logic                err_q, err_d;

    logic [31:0]         enc_word;
    logic                enc_legal;
    logic                accept;
    logic                restart;
    logic [ADDR_W:0]     slot;
    logic                slot_is_last;

    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (in_op)
            4'd0:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
            4'd1:  enc_word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
            4'd2:  enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
            4'd3:  enc_word = {7'b0100000, in_imm[4:0], in_rs1, 3'b101, in_rd, 7'b0010011};
            4'd4:  enc_word = {7'b0000000, in_imm[4:0], in_rs1, 3'b101, in_rd, 7'b0010011};
            4'd5:  enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
            4'd6:  enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
            4'd7:  enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                               in_imm[4:1], in_imm[11], 7'b1100011};
            4'd8:  enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b001,
                               in_imm[4:1], in_imm[11], 7'b1100011};
            4'd9:  enc_word = {in_imm[31:12], in_rd, 7'b0110111};
            4'd10: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                               in_rd, 7'b1101111};
            4'd11: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
            default: enc_legal = 1'b0;
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign restart = start && ((state_q == StIdle) || (state_q == StDone));

    // Address the word accepted this cycle will land at (one ahead if a write is in flight).
    assign slot         = {1'b0, ptr_q} + {{ADDR_W{1'b0}}, pend_q};
    assign slot_is_last = (slot == {1'b0, MaxAddr});

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        wdata_d = wdata_q;
        pend_d  = 1'b0;
        term_d  = term_q;
        full_d  = full_q;
        err_d   = err_q;
        if (restart) begin
            ptr_d   = BaseAddr;
            count_d = '0;
            term_d  = 1'b0;
            full_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            if (imem_we) begin
                count_d = count_q + (ADDR_W+1)'(1);
                // Pointer saturates at the top word instead of wrapping.
                if (ptr_q == MaxAddr) begin
                    full_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            if (accept) begin
                if (enc_legal) begin
                    pend_d  = 1'b1;
                    wdata_d = enc_word;
                end else begin
                    err_d = 1'b1;
                end
                if (in_last || (enc_legal && slot_is_last)) begin
                    term_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= BaseAddr;
            count_q <= '0;
            wdata_q <= '0;
            pend_q  <= 1'b0;
            term_q  <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            pend_q  <= pend_d;
            term_q  <= term_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) state_d = StLoad;
            end
            StLoad: begin
                // Any final write completes during this cycle.
                if (term_q) begin
`ifdef HALT_APPEND_EN
                    if (full_q || (pend_q && (ptr_q == MaxAddr))) begin
                        state_d = StDone;
                    end else begin
                        state_d = StHalt;
                    end
`else
                    state_d = StDone;
`endif
                end
            end
            StHalt:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready    = (state_q == StLoad) && !term_q;
        imem_we     = 1'b0;
        imem_addr   = '0;
        imem_wdata  = '0;
        load_done   = (state_q == StDone);
        word_count  = count_q;
        err_illegal = err_q;
        if ((state_q == StLoad) && pend_q) begin
            imem_we    = 1'b1;
            imem_addr  = ptr_q;
            imem_wdata = wdata_q;
        end
`ifdef HALT_APPEND_EN
        if (state_q == StHalt) begin
            imem_we    = 1'b1;
            imem_addr  = ptr_q;
            imem_wdata = HaltWord;
        end
`endif
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench for instr_encode_loader: encoding table, illegal ops, capacity limit, reset.
module tb_instr_encode_loader;

`ifdef HALT_APPEND_EN
    localparam int HaltW = 1;
`else
    localparam int HaltW = 0;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, in_valid, in_last, sel;
    logic [3:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;

    logic        start_b, valid_b, ready_b, we_b, done_b, err_b;
    logic [7:0]  addr_b;
    logic [31:0] wdata_b;
    logic [8:0]  cnt_b;
    logic        start_s, valid_s, ready_s, we_s, done_s, err_s;
    logic [1:0]  addr_s;
    logic [31:0] wdata_s;
    logic [2:0]  cnt_s;

    logic        m_ready, m_we, m_done, m_err;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    logic [8:0]  m_cnt;

    assign start_b = start & ~sel;
    assign valid_b = in_valid & ~sel;
    assign start_s = start & sel;
    assign valid_s = in_valid & sel;
    assign m_ready = sel ? ready_s : ready_b;
    assign m_we    = sel ? we_s : we_b;
    assign m_done  = sel ? done_s : done_b;
    assign m_err   = sel ? err_s : err_b;
    assign m_addr  = sel ? {6'b0, addr_s} : addr_b;
    assign m_wdata = sel ? wdata_s : wdata_b;
    assign m_cnt   = sel ? {6'b0, cnt_s} : cnt_b;

    instr_encode_loader #(.ADDR_W(8), .BASE_ADDR(0)) u_big (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(valid_b), .in_ready(ready_b),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
        .load_done(done_b), .word_count(cnt_b), .err_illegal(err_b)
    );

    instr_encode_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_s), .in_valid(valid_s), .in_ready(ready_s),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .imem_we(we_s), .imem_addr(addr_s), .imem_wdata(wdata_s),
        .load_done(done_s), .word_count(cnt_s), .err_illegal(err_s)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    exp_t       sbq[$];
    exp_t       mon_e;
    logic [7:0] exp_ptr;
    vec_t       tab[12];
    vec_t       ill;

    // Every observed write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && m_we) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_bad++;
                $display("FAIL wr_unexpected: got addr %0d data %h, required no write",
                         m_addr, m_wdata);
            end else begin
                mon_e = sbq.pop_front();
                if (m_addr !== mon_e.addr || m_wdata !== mon_e.data) begin
                    n_bad++;
                    $display("FAIL wr: got addr %0d data %h, required addr %0d data %h",
                             m_addr, m_wdata, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] word);
        exp_t e;
        e.addr = exp_ptr;
        e.data = word;
        sbq.push_back(e);
        exp_ptr++;
    endtask

    task automatic push_halt();
`ifdef HALT_APPEND_EN
        push_exp(32'h0000_006F);
`endif
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_ptr = 8'd0;
    endtask

    task automatic send(input vec_t v, input logic last, input logic legal);
        in_op = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
        in_last = last;
        in_valid = 1'b1;
        for (int c = 0; c < 50 && !m_ready; c++) tick();
        if (!m_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready got 0, required 1");
        end else begin
            if (legal) push_exp(v.word);
            tick();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int c = 0; c < 50 && !m_done; c++) tick();
        chk(name, {31'b0, m_done}, 32'd1);
    endtask

    initial begin
        tab[0]  = '{4'd0,  5'd3, 5'd1, 5'd2, 32'h0000_0000, 32'h0020_81B3};
        tab[1]  = '{4'd1,  5'd3, 5'd1, 5'd2, 32'h0000_0000, 32'h4020_81B3};
        tab[2]  = '{4'd2,  5'd5, 5'd0, 5'd0, 32'h0000_0010, 32'h0100_0293};
        tab[3]  = '{4'd6,  5'd0, 5'd1, 5'd2, 32'h0000_0008, 32'h0020_A423};
        tab[4]  = '{4'd7,  5'd0, 5'd1, 5'd2, 32'h0000_0008, 32'h0020_8463};
        tab[5]  = '{4'd9,  5'd1, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_50B7};
        tab[6]  = '{4'd3,  5'd4, 5'd3, 5'd0, 32'hFFFF_FFE5, 32'h4051_D213};
        tab[7]  = '{4'd4,  5'd4, 5'd3, 5'd0, 32'h0000_0005, 32'h0051_D213};
        tab[8]  = '{4'd5,  5'd6, 5'd2, 5'd0, 32'hFFFF_FFFC, 32'hFFC1_2303};
        tab[9]  = '{4'd8,  5'd0, 5'd5, 5'd6, 32'hFFFF_FFF8, 32'hFE62_9CE3};
        tab[10] = '{4'd10, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0010_00EF};
        tab[11] = '{4'd11, 5'd0, 5'd1, 5'd0, 32'h0000_0000, 32'h0000_8067};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; sel = 1'b0;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; exp_ptr = '0;
        #22;
        rst_n = 1'b1;
        tick();
        chk("rst_ready", {31'b0, m_ready}, 32'd0);
        chk("rst_we", {31'b0, m_we}, 32'd0);
        chk("rst_done", {31'b0, m_done}, 32'd0);
        chk("rst_count", {23'b0, m_cnt}, 32'd0);
        chk("rst_err", {31'b0, m_err}, 32'd0);

        // ADD then SUB back to back
        do_start();
        chk("start_ready", {31'b0, m_ready}, 32'd1);
        send(tab[0], 1'b0, 1'b1);
        chk("addsub_we0", {31'b0, m_we}, 32'd1);
        send(tab[1], 1'b1, 1'b1);
        chk("addsub_we1", {31'b0, m_we}, 32'd1);
        chk("addsub_ready_drop", {31'b0, m_ready}, 32'd0);
        push_halt();
        wait_done("addsub_done");
        chk("addsub_count", {23'b0, m_cnt}, 32'(2 + HaltW));
        chk("addsub_drained", 32'(sbq.size()), 32'd0);

        // Single ADDI with in_last: done latency
        do_start();
        send(tab[2], 1'b1, 1'b1);
        chk("addi_ready", {31'b0, m_ready}, 32'd0);
        chk("addi_done_early", {31'b0, m_done}, 32'd0);
        push_halt();
        tick();
`ifdef HALT_APPEND_EN
        chk("addi_halt_we", {31'b0, m_we}, 32'd1);
        chk("addi_halt_notdone", {31'b0, m_done}, 32'd0);
        tick();
`endif
        chk("addi_done", {31'b0, m_done}, 32'd1);
        chk("addi_count", {23'b0, m_cnt}, 32'(1 + HaltW));

        // Full encoding table in one streamed session
        do_start();
        for (int i = 0; i < 12; i++) send(tab[i], (i == 11), 1'b1);
        push_halt();
        wait_done("table_done");
        chk("table_count", {23'b0, m_cnt}, 32'(12 + HaltW));
        chk("table_err", {31'b0, m_err}, 32'd0);
        chk("table_drained", 32'(sbq.size()), 32'd0);

        // Illegal op between two ADDs
        ill = tab[0];
        ill.op = 4'd13;
        do_start();
        chk("restart_err_clear", {31'b0, m_err}, 32'd0);
        send(tab[0], 1'b0, 1'b1);
        send(ill, 1'b0, 1'b0);
        chk("ill_err_set", {31'b0, m_err}, 32'd1);
        send(tab[0], 1'b1, 1'b1);
        push_halt();
        wait_done("ill_done");
        chk("ill_count", {23'b0, m_cnt}, 32'(2 + HaltW));
        chk("ill_err_sticky", {31'b0, m_err}, 32'd1);
        chk("ill_drained", 32'(sbq.size()), 32'd0);

        // Capacity limit on a 4-word instance, in_valid held high
        sel = 1'b1;
        do_start();
        begin
            int acc;
            acc = 0;
            in_op = tab[1].op; in_rd = tab[1].rd; in_rs1 = tab[1].rs1;
            in_rs2 = tab[1].rs2; in_imm = tab[1].imm;
            in_valid = 1'b1;
            for (int c = 0; c < 8; c++) begin
                if (m_ready) begin
                    push_exp(tab[1].word);
                    acc++;
                end
                tick();
            end
            in_valid = 1'b0;
            chk("cap_accepts", 32'(acc), 32'd4);
        end
        chk("cap_ready", {31'b0, m_ready}, 32'd0);
        wait_done("cap_done");
        chk("cap_count", {23'b0, m_cnt}, 32'd4);
        chk("cap_err", {31'b0, m_err}, 32'd0);
        chk("cap_drained", 32'(sbq.size()), 32'd0);
        sel = 1'b0;

        // Asynchronous reset during a write cycle
        do_start();
        send(tab[0], 1'b1, 1'b1);
        chk("rstw_we_before", {31'b0, m_we}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstw_we", {31'b0, m_we}, 32'd0);
        chk("rstw_addr", {24'b0, m_addr}, 32'd0);
        chk("rstw_wdata", m_wdata, 32'd0);
        chk("rstw_done", {31'b0, m_done}, 32'd0);
        chk("rstw_count", {23'b0, m_cnt}, 32'd0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_start();
        send(tab[1], 1'b1, 1'b1);
        push_halt();
        wait_done("rstw_restart_done");
        chk("rstw_restart_count", {23'b0, m_cnt}, 32'(1 + HaltW));
        chk("rstw_drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
